// File: rtl/ram_loader_if.sv
// rtl/ram_loader_if.sv - bus bundle joining ram_loader to its control, download, CPU and RAM sides
interface ram_loader_if #(
  parameter int addr_width_g    = 11,
  parameter int data_width_g    = 8,
  parameter int dl_addr_width_g = 25
);
  logic                       clear_req;
  logic                       dl_busy;
  logic                       dl_wr;
  logic [dl_addr_width_g-1:0] dl_addr;
  logic [7:0]                 dl_data;
  logic [addr_width_g-1:0]    cpu_address;
  logic [data_width_g-1:0]    cpu_data;
  logic                       cpu_wren;
  logic                       cpu_stall;
  logic [addr_width_g-1:0]    ram_address;
  logic [data_width_g-1:0]    ram_data;
  logic                       ram_wren;
  logic [addr_width_g:0]      load_count;
  logic                       done;
  logic                       dl_err;

  modport master (
    output clear_req, dl_busy, dl_wr, dl_addr, dl_data,
    output cpu_address, cpu_data, cpu_wren,
    input  cpu_stall, ram_address, ram_data, ram_wren,
    input  load_count, done, dl_err
  );

  modport slave (
    input  clear_req, dl_busy, dl_wr, dl_addr, dl_data,
    input  cpu_address, cpu_data, cpu_wren,
    output cpu_stall, ram_address, ram_data, ram_wren,
    output load_count, done, dl_err
  );
endinterface

// File: rtl/ram_loader.sv
// rtl/ram_loader.sv - write-side front end for a block RAM: zero-fill, windowed download preload, CPU pass-through
module ram_loader #(
  parameter int addr_width_g    = 11,
  parameter int data_width_g    = 8,
  parameter int base_g          = 0,
  parameter int dl_addr_width_g = 25
) (
  input  logic        clock,
  input  logic        reset_n,
  ram_loader_if.slave bus
);
  localparam int N   = addr_width_g;
  localparam int DW  = data_width_g;
  localparam int DLW = dl_addr_width_g;
  localparam logic [DLW-1:0] BASE = DLW'(base_g);
  localparam logic [N:0]     SAT  = {1'b1, {N{1'b0}}};

  typedef enum logic [1:0] {ST_CLEAR, ST_IDLE, ST_LOAD} state_t;

  state_t          r_state;
  logic [N:0]      r_sweep;
  logic            r_wren;
  logic [N-1:0]    r_addr;
  logic [DW-1:0]   r_data;
  logic [N:0]      r_load_count;
  logic            r_done;
  logic            r_err;
  logic            r_stall;

  logic [DLW-1:0]  w_offset;
  logic            w_in_window;
  logic            w_pass;

  // Range check on the full-width offset so addresses past the window never alias into it.
  assign w_offset    = bus.dl_addr - BASE;
  assign w_in_window = (bus.dl_addr >= BASE) && ((w_offset >> N) == '0);

  // A final LOAD write can land in the first IDLE cycle; it takes the RAM port over the CPU.
  assign w_pass = (r_state == ST_IDLE) && !r_wren;

  assign bus.ram_address = w_pass ? bus.cpu_address : r_addr;
  assign bus.ram_data    = w_pass ? bus.cpu_data    : r_data;
  assign bus.ram_wren    = w_pass ? bus.cpu_wren    : r_wren;
  assign bus.cpu_stall   = r_stall;
  assign bus.load_count  = r_load_count;
  assign bus.done        = r_done;
  assign bus.dl_err      = r_err;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state      <= ST_CLEAR;
      r_sweep      <= '0;
      r_wren       <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_load_count <= '0;
      r_done       <= 1'b0;
      r_err        <= 1'b0;
      r_stall      <= 1'b1;
    end else begin
      r_done  <= 1'b0;
      r_wren  <= 1'b0;
      r_stall <= (r_state != ST_IDLE);
      case (r_state)
        ST_CLEAR: begin
          if (bus.dl_wr) r_err <= 1'b1;
          if (r_sweep[N]) begin
            r_done  <= 1'b1;
            r_state <= bus.dl_busy ? ST_LOAD : ST_IDLE;
          end else begin
            r_wren  <= 1'b1;
            r_addr  <= r_sweep[N-1:0];
            r_data  <= '0;
            r_sweep <= r_sweep + 1'b1;
          end
        end
        ST_IDLE: begin
          if (bus.clear_req) begin
            r_state <= ST_CLEAR;
            r_sweep <= '0;
          end else if (bus.dl_busy) begin
            r_state      <= ST_LOAD;
            r_load_count <= '0;
          end
        end
        ST_LOAD: begin
          if (bus.dl_wr && w_in_window) begin
            r_wren <= 1'b1;
            r_addr <= w_offset[N-1:0];
            r_data <= DW'(bus.dl_data);
            if (r_load_count != SAT) r_load_count <= r_load_count + 1'b1;
          end
          if (!bus.dl_busy) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= ST_CLEAR;
      endcase
    end
  end
endmodule

// File: tb/tb_ram_loader.sv
// tb/tb_ram_loader.sv - randomized scoreboard bench for ram_loader
`timescale 1ns/1ps
module tb_ram_loader;
  localparam int N     = 4;
  localparam int DEPTH = 16;
  localparam int BASE  = 'h100;
  localparam int DLW   = 25;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  ram_loader_if #(.addr_width_g(N), .data_width_g(8), .dl_addr_width_g(DLW)) bus ();

  ram_loader #(
    .addr_width_g(N), .data_width_g(8), .base_g(BASE), .dl_addr_width_g(DLW)
  ) dut (
    .clock(clock), .reset_n(reset_n), .bus(bus)
  );

  wr_t        exp_q[$];
  wr_t        mon_e;
  logic [7:0] exp_mem [DEPTH];
  logic [7:0] ram [DEPTH];
  logic [7:0] ram_q;
  int         exp_count;
  int         checks = 0;
  int         errors = 0;

  always @(posedge clock) begin
    if (bus.ram_wren === 1'b1) ram[bus.ram_address] <= bus.ram_data;
    ram_q <= ram[bus.ram_address];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (bus.ram_wren === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write: got write addr 0x%0h data 0x%0h, required no write",
                 bus.ram_address, bus.ram_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 32'(bus.ram_address), 32'(mon_e.addr));
        check("wr_data", 32'(bus.ram_data), 32'(mon_e.data));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, required completion");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clear_req = 0; bus.dl_busy = 0; bus.dl_wr = 0; bus.dl_addr = '0; bus.dl_data = '0;
    bus.cpu_address = '0; bus.cpu_data = '0; bus.cpu_wren = 0;
  endtask

  task automatic push_clear();
    for (int i = 0; i < DEPTH; i++) begin
      exp_q.push_back({4'(i), 8'h00});
      exp_mem[i] = 8'h00;
    end
  endtask

  task automatic model_dl(input logic [DLW-1:0] a, input logic [7:0] d);
    int off;
    if (int'(a) >= BASE && int'(a) < BASE + DEPTH) begin
      off = int'(a) - BASE;
      exp_q.push_back({4'(off), d});
      exp_mem[off] = d;
      if (exp_count < DEPTH) exp_count++;
    end
  endtask

  task automatic wait_done(input string name, input int budget, output int n);
    bit found = 0;
    n = 0;
    for (int i = 1; i <= budget && !found; i++) begin
      @(negedge clock);
      if (bus.done === 1'b1) begin
        found = 1;
        n = i;
      end
    end
    check({name, "_seen"}, 32'(found), 32'd1);
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < DEPTH; i++)
      check($sformatf("%s_mem[%0d]", tag, i), 32'(ram[i]), 32'(exp_mem[i]));
  endtask

  task automatic send_byte(input logic [DLW-1:0] a, input logic [7:0] d);
    bus.dl_wr = 1; bus.dl_addr = a; bus.dl_data = d;
    model_dl(a, d);
    tick();
    bus.dl_wr = 0;
  endtask

  task automatic start_session();
    bus.dl_busy = 1;
    exp_count = 0;
    tick();
  endtask

  task automatic end_session(input bit final_wr, input logic [DLW-1:0] a, input logic [7:0] d,
                             input bit chk_count);
    int n;
    bus.cpu_wren = 0; bus.clear_req = 0; bus.dl_busy = 0;
    if (final_wr) begin
      bus.dl_wr = 1; bus.dl_addr = a; bus.dl_data = d;
      model_dl(a, d);
    end
    tick();
    bus.dl_wr = 0;
    wait_done("load_done", 6, n);
    if (chk_count) check("load_count", 32'(bus.load_count), 32'(exp_count));
    @(negedge clock);
    check("load_done_width", 32'(bus.done), 32'd0);
    check("load_stall_low", 32'(bus.cpu_stall), 32'd0);
    tick();
  endtask

  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
    bus.cpu_address = a; bus.cpu_data = d; bus.cpu_wren = 1;
    exp_q.push_back({a, d});
    exp_mem[a] = d;
    #1;
    check("pass_addr", 32'(bus.ram_address), 32'(a));
    check("pass_data", 32'(bus.ram_data), 32'(d));
    check("pass_wren", 32'(bus.ram_wren), 32'd1);
    tick();
    bus.cpu_wren = 0;
  endtask

  task automatic random_session(input int nbytes);
    logic [DLW-1:0] a;
    start_session();
    for (int k = 0; k < nbytes; k++) begin
      if ($urandom_range(0, 3) == 0) begin
        bus.cpu_wren = 1; bus.cpu_address = 4'($urandom); bus.cpu_data = 8'($urandom);
        bus.clear_req = 1'($urandom);
        tick();
        bus.cpu_wren = 0; bus.clear_req = 0;
      end
      a = DLW'(BASE - 16 + $urandom_range(0, 47));
      send_byte(a, 8'($urandom));
    end
    a = DLW'(BASE - 16 + $urandom_range(0, 47));
    end_session(1'($urandom), a, 8'($urandom), 1);
  endtask

  initial begin
    int n;
    logic [7:0] last_d;
    reset_n = 0;
    idle_inputs();
    exp_count = 0;
    repeat (2) tick();
    check("rst_wren", 32'(bus.ram_wren), 32'd0);
    check("rst_addr", 32'(bus.ram_address), 32'd0);
    check("rst_data", 32'(bus.ram_data), 32'd0);
    check("rst_count", 32'(bus.load_count), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.dl_err), 32'd0);
    check("rst_stall", 32'(bus.cpu_stall), 32'd1);

    reset_n = 1;
    push_clear();
    wait_done("reset_clear", 40, n);
    check("reset_clear_cycles", 32'(n), 32'd18);
    @(negedge clock);
    check("clear_done_width", 32'(bus.done), 32'd0);
    check("clear_stall_low", 32'(bus.cpu_stall), 32'd0);
    check("clear_drained", 32'(exp_q.size()), 32'd0);
    check_mem("reset_clear");
    tick();

    cpu_write(4'd5, 8'h5A);
    tick();
    check("cpu_readback", 32'(ram_q), 32'h5A);
    repeat (3) cpu_write(4'($urandom), 8'($urandom));

    start_session();
    send_byte(DLW'('h0FF), 8'hAA);
    send_byte(DLW'('h100), 8'h11);
    send_byte(DLW'('h10F), 8'h22);
    send_byte(DLW'('h110), 8'hBB);
    end_session(0, '0, '0, 1);
    check("window_count", 32'(bus.load_count), 32'd2);
    check("window_mem0", 32'(ram[0]), 32'h11);
    check("window_mem15", 32'(ram[15]), 32'h22);
    check("window_drained", 32'(exp_q.size()), 32'd0);

    bus.clear_req = 1;
    push_clear();
    tick();
    bus.clear_req = 0;
    repeat (5) tick();
    bus.dl_busy = 1; bus.dl_wr = 1; bus.dl_addr = DLW'(BASE + 5); bus.dl_data = 8'h77;
    tick();
    bus.dl_wr = 0;
    wait_done("dl_clear", 40, n);
    check("dl_err_set", 32'(bus.dl_err), 32'd1);
    @(negedge clock);
    check("clear_to_load_stall", 32'(bus.cpu_stall), 32'd1);
    tick();
    send_byte(DLW'(BASE + 7), 8'h3C);
    end_session(0, '0, '0, 0);
    check_mem("dl_clear");

    start_session();
    for (int i = 0; i < 3; i++) send_byte(DLW'(BASE + $urandom_range(0, 15)), 8'($urandom));
    check("err_sticky", 32'(bus.dl_err), 32'd1);
    reset_n = 0; bus.dl_busy = 0;
    tick();
    check("midrst_wren", 32'(bus.ram_wren), 32'd0);
    check("midrst_count", 32'(bus.load_count), 32'd0);
    check("midrst_err", 32'(bus.dl_err), 32'd0);
    check("midrst_stall", 32'(bus.cpu_stall), 32'd1);
    reset_n = 1;
    push_clear();
    wait_done("midrst_clear", 40, n);
    check("midrst_clear_cycles", 32'(n), 32'd18);
    @(negedge clock);
    check_mem("midrst");
    tick();

    start_session();
    for (int i = 0; i < DEPTH; i++) send_byte(DLW'(BASE + i), 8'($urandom));
    last_d = 8'($urandom);
    send_byte(DLW'(BASE + 3), last_d);
    end_session(0, '0, '0, 1);
    check("sat_count", 32'(bus.load_count), 32'd16);
    check("sat_repeat", 32'(ram[3]), 32'(last_d));
    check_mem("sat");

    repeat (6) begin
      repeat (2) cpu_write(4'($urandom), 8'($urandom));
      random_session($urandom_range(3, 20));
      check_mem("rand");
    end

    bus.clear_req = 1;
    push_clear();
    tick();
    bus.clear_req = 0;
    wait_done("req_clear", 40, n);
    check("req_clear_cycles", 32'(n), 32'd18);
    @(negedge clock);
    check_mem("req_clear");
    check("final_drained", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
